// File: rtl/mcp_pkg.sv
// Shared definitions for the MCP launch side: FSM state encoding and the
// bus reset pattern that the remote capture register also resets to.
package mcp_pkg;

  localparam int unsigned MCP_MAX_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    CAPT = 2'd2
  } mcp_state_t;

  // Alternating pattern: odd bits 1, even bits 0, upper bits beyond width clear.
  function automatic logic [MCP_MAX_WIDTH-1:0] mcp_rst_pattern(input int unsigned width);
    logic [MCP_MAX_WIDTH-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < MCP_MAX_WIDTH; i++) begin
      if (i < width) p[i] = i[0];
    end
    return p;
  endfunction

endpackage

// File: rtl/mcp_hold_counter.sv
// Loadable down-counter that times the stable-bus window; saturates at zero.
module mcp_hold_counter #(
  parameter int unsigned width = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [width-1:0] load_val,
  input  logic             en,
  output logic             zero_c
);

  logic [width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - width'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mcp_launch_ctrl.sv
// Launch-side MCP controller: accepts a word, holds it on the MCP bus for
// hold_cycles cycles, then pulses the capture enable for one cycle.
module mcp_launch_ctrl
  import mcp_pkg::*;
#(
  parameter int unsigned width       = 1,
  parameter int unsigned hold_cycles = 2,
  parameter int unsigned cnt_width   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     in_data,
  output logic [width-1:0]     mcp_val,
  output logic                 mcp_set,
  output logic                 busy,
  output logic                 done,
  output logic [cnt_width-1:0] xfer_count
);

  localparam int unsigned HCW = (hold_cycles > 2) ? $clog2(hold_cycles) : 1;
  localparam logic [width-1:0] RST_PAT = width'(mcp_rst_pattern(width));
  localparam logic [HCW-1:0] HOLD_LOAD = (hold_cycles >= 2) ? HCW'(hold_cycles - 2) : '0;

  if (hold_cycles < 1) begin : g_bad_hold
    $error("mcp_launch_ctrl: hold_cycles must be at least 1");
  end
  if (width < 1 || width > MCP_MAX_WIDTH) begin : g_bad_width
    $error("mcp_launch_ctrl: width out of range");
  end

  mcp_state_t           state_q, state_d;
  logic [width-1:0]     val_q, val_d;
  logic                 done_q, done_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic                 hc_load_c, hc_en_c, hc_zero_c;

  mcp_hold_counter #(.width(HCW)) u_hold_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (hc_load_c),
    .load_val (HOLD_LOAD),
    .en       (hc_en_c),
    .zero_c   (hc_zero_c)
  );

  // Next-state, bus data and completion bookkeeping.
  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    hc_load_c = 1'b0;
    hc_en_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          val_d = in_data;
          if (hold_cycles == 1) begin
            state_d = CAPT;
          end else begin
            hc_load_c = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        hc_en_c = 1'b1;
        if (hc_zero_c) state_d = CAPT;
      end
      CAPT: begin
        state_d = IDLE;
        done_d  = 1'b1;
        cnt_d   = cnt_q + cnt_width'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      val_q   <= RST_PAT;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake and capture enable are gated by RST so an aborted CAPT never fires.
  assign in_ready   = (state_q == IDLE) && !RST;
  assign mcp_set    = (state_q == CAPT) && !RST;
  assign busy       = (state_q != IDLE);
  assign mcp_val    = val_q;
  assign done       = done_q;
  assign xfer_count = cnt_q;

endmodule
